// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
//   seq_state_e : sequencer FSM states
//   AESxxx_NR   : round counts per key size
//   DEFAULT_KIW : default round-key index width
package aes_seq_pkg;

    localparam int unsigned AES128_NR   = 10;
    localparam int unsigned AES192_NR   = 12;
    localparam int unsigned AES256_NR   = 14;
    localparam int unsigned DEFAULT_KIW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_seq_rcnt.sv
// Round counter and round-key index generator.
//   clock, reset : system clock, synchronous active-high reset
//   init_ph      : sequencer is in the initial AddRoundKey cycle (loads count 1)
//   round_ph     : sequencer is in a round cycle (count advances, saturating at NR)
//   en_de        : 1 = encrypt (index counts up), 0 = decrypt (index = NR - count)
//   rk_idx_c     : key index for this cycle, 0 outside init/round phases
//   last_c       : final round flag
module aes_seq_rcnt #(
    parameter int unsigned NR  = 10,
    parameter int unsigned KIW = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           init_ph,
    input  logic           round_ph,
    input  logic           en_de,
    output logic [KIW-1:0] rk_idx_c,
    output logic           last_c
);

    localparam logic [KIW-1:0] NR_K = KIW'(NR);

    logic [KIW-1:0] rcnt_q;

    // Count register; saturates at NR so it can never wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt_q <= '0;
        end else if (init_ph) begin
            rcnt_q <= KIW'(1);
        end else if (round_ph && (rcnt_q != NR_K)) begin
            rcnt_q <= rcnt_q + KIW'(1);
        end
    end

    // Key index: ascending for encrypt, descending from NR for decrypt.
    always_comb begin
        rk_idx_c = '0;
        last_c   = 1'b0;
        if (init_ph) begin
            rk_idx_c = en_de ? '0 : NR_K;
        end else if (round_ph) begin
            rk_idx_c = en_de ? rcnt_q : (NR_K - rcnt_q);
            last_c   = (rcnt_q == NR_K);
        end
    end

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES round sequencer: initial AddRoundKey, then NR passes through an
// external single-round datapath, fetching round keys by index.
//   clock, reset          : system clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake; in_en_de 1 = encrypt; in_block payload
//   flush                 : abort the current transaction (ignored in IDLE)
//   rk_idx / rk_data      : round-key fetch, key returned in the same cycle
//   rnd_en_de, rnd_last,
//   rnd_block, rnd_key    : drive the round datapath
//   rnd_result            : datapath new block
//   out_valid/out_ready   : result handshake; out_block payload
// Optional macro AES_ROUND_SEQ_SINGLE_EN adds in_single/in_last for one-round
// requests (skip INIT, one ROUND with key 0 and last = in_last).
module aes_round_seq
    import aes_seq_pkg::*;
#(
    parameter int unsigned NR  = AES128_NR,
    parameter int unsigned KIW = DEFAULT_KIW
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_en_de,
`ifdef AES_ROUND_SEQ_SINGLE_EN
    input  logic           in_single,
    input  logic           in_last,
`endif
    input  logic [127:0]   in_block,
    input  logic           flush,
    output logic [KIW-1:0] rk_idx,
    input  logic [127:0]   rk_data,
    output logic           rnd_en_de,
    output logic           rnd_last,
    output logic [127:0]   rnd_block,
    output logic [127:0]   rnd_key,
    input  logic [127:0]   rnd_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_block
);

    seq_state_e     st_q, st_d;
    logic [127:0]   blk_q, blk_d;
    logic           dir_q, dir_d;
    logic           accept;
    logic           round_done;
    logic [KIW-1:0] cnt_idx;
    logic           cnt_last;
    logic           single_rnd;

`ifdef AES_ROUND_SEQ_SINGLE_EN
    logic single_q, single_d;
    logic last_q, last_d;
`endif

    aes_seq_rcnt #(
        .NR  (NR),
        .KIW (KIW)
    ) u_rcnt (
        .clock    (clock),
        .reset    (reset),
        .init_ph  (st_q == ST_INIT),
        .round_ph (st_q == ST_ROUND),
        .en_de    (dir_q),
        .rk_idx_c (cnt_idx),
        .last_c   (cnt_last)
    );

`ifdef AES_ROUND_SEQ_SINGLE_EN
    assign single_rnd = single_q && (st_q == ST_ROUND);
`else
    assign single_rnd = 1'b0;
`endif

    assign round_done = single_rnd || cnt_last;

    // State, data and direction registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q  <= ST_IDLE;
            blk_q <= '0;
            dir_q <= 1'b0;
`ifdef AES_ROUND_SEQ_SINGLE_EN
            single_q <= 1'b0;
            last_q   <= 1'b0;
`endif
        end else begin
            st_q  <= st_d;
            blk_q <= blk_d;
            dir_q <= dir_d;
`ifdef AES_ROUND_SEQ_SINGLE_EN
            single_q <= single_d;
            last_q   <= last_d;
`endif
        end
    end

    // Next-state and handshake logic; flush wins over everything outside IDLE.
    always_comb begin
        st_d     = st_q;
        blk_d    = blk_q;
        dir_d    = dir_q;
        in_ready = 1'b0;
        accept   = 1'b0;
`ifdef AES_ROUND_SEQ_SINGLE_EN
        single_d = single_q;
        last_d   = last_q;
`endif
        case (st_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            ST_INIT: begin
                if (flush) begin
                    st_d = ST_IDLE;
                end else begin
                    blk_d = blk_q ^ rk_data;
                    st_d  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (flush) begin
                    st_d = ST_IDLE;
                end else begin
                    blk_d = rnd_result;
                    if (round_done) st_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Accept overlaps result delivery; a flush blocks both.
                in_ready = out_ready && !flush;
                if (flush) begin
                    st_d = ST_IDLE;
                end else if (out_ready) begin
                    if (in_valid) accept = 1'b1;
                    else          st_d   = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        if (accept) begin
            blk_d = in_block;
            dir_d = in_en_de;
            st_d  = ST_INIT;
`ifdef AES_ROUND_SEQ_SINGLE_EN
            single_d = in_single;
            last_d   = in_last;
            if (in_single) st_d = ST_ROUND;
`endif
        end
    end

`ifdef AES_ROUND_SEQ_SINGLE_EN
    assign rk_idx   = single_rnd ? '0 : cnt_idx;
    assign rnd_last = single_rnd ? last_q : cnt_last;
`else
    assign rk_idx   = cnt_idx;
    assign rnd_last = cnt_last;
`endif

    assign rnd_en_de = dir_q;
    assign rnd_block = blk_q;
    assign rnd_key   = rk_data;
    assign out_valid = (st_q == ST_DONE);
    assign out_block = blk_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq: behavioural AES round datapath and key
// file around the DUT, full-cipher reference, FIPS-197 C.1 plus random blocks.
module tb_aes_round_seq;

    localparam int NR  = 10;
    localparam int KIW = 4;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           in_en_de;
    logic [127:0]   in_block;
    logic           flush;
    logic [KIW-1:0] rk_idx;
    logic [127:0]   rk_data;
    logic           rnd_en_de;
    logic           rnd_last;
    logic [127:0]   rnd_block;
    logic [127:0]   rnd_key;
    logic [127:0]   rnd_result;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_block;
`ifdef AES_ROUND_SEQ_SINGLE_EN
    logic           in_single;
    logic           in_last;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk_file [16];

    always #5 clock = ~clock;

    aes_round_seq #(.NR(NR), .KIW(KIW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_en_de   (in_en_de),
`ifdef AES_ROUND_SEQ_SINGLE_EN
        .in_single  (in_single),
        .in_last    (in_last),
`endif
        .in_block   (in_block),
        .flush      (flush),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .rnd_en_de  (rnd_en_de),
        .rnd_last   (rnd_last),
        .rnd_block  (rnd_block),
        .rnd_key    (rnd_key),
        .rnd_result (rnd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block)
    );

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(logic [7:0] v, int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // One AES round as the external datapath would compute it.
    function automatic logic [127:0] dp_round(logic [127:0] b, logic [127:0] k,
                                              logic enc, logic last);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = b[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
                if (enc) t[q+4*c] = sbox[s[q+4*((c+q)%4)]];
                else     t[q+4*((c+q)%4)] = isbox[s[q+4*c]];
        if (!enc)
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (enc) begin
                    t[4*c]   = gmul(a0,8'd2) ^ gmul(a1,8'd3) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1,8'd2) ^ gmul(a2,8'd3) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2,8'd2) ^ gmul(a3,8'd3);
                    t[4*c+3] = gmul(a0,8'd3) ^ a1 ^ a2 ^ gmul(a3,8'd2);
                end else begin
                    t[4*c]   = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
                    t[4*c+1] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
                    t[4*c+2] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
                    t[4*c+3] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
                end
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return enc ? (r ^ k) : r;
    endfunction

    assign rk_data    = rk_file[rk_idx];
    assign rnd_result = dp_round(rnd_block, rnd_key, rnd_en_de, rnd_last);

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rol8(inv,1) ^ rol8(inv,2) ^ rol8(inv,3) ^ rol8(inv,4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_file[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] aes_ref(logic [127:0] blk, logic enc);
        logic [127:0] s;
        if (enc) begin
            s = blk ^ rk_file[0];
            for (int r = 1; r <= NR; r++) s = dp_round(s, rk_file[r], 1'b1, r == NR);
        end else begin
            s = blk ^ rk_file[NR];
            for (int r = NR - 1; r >= 0; r--) s = dp_round(s, rk_file[r], 1'b0, r == 0);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request in IDLE/DONE and take the accepting edge.
    task automatic start(input logic enc, input logic [127:0] blk, input logic fl);
        in_valid = 1'b1; in_en_de = enc; in_block = blk; flush = fl;
        #1 check("accept in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    // Walk INIT and ROUND cycles after the accept, then check the result.
    task automatic follow(input logic enc, input logic [127:0] exp, input string tag);
        for (int c = 0; c <= NR; c++) begin
            check({tag, " rk_idx"}, 128'(rk_idx), 128'(enc ? c : NR - c));
            check({tag, " rnd_last"}, 128'(rnd_last), 128'(c == NR));
            check({tag, " early out_valid"}, 128'(out_valid), 128'(1'b0));
            tick();
        end
        check({tag, " out_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, " out_block"}, out_block, exp);
        check({tag, " done in_ready"}, 128'(in_ready), 128'(1'b0));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("drain out_valid", 128'(out_valid), 128'(1'b0));
        check("drain in_ready", 128'(in_ready), 128'(1'b1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"},  128'(in_ready),  128'(1'b1));
        check({tag, " out_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, " out_block"}, out_block, 128'h0);
        check({tag, " rk_idx"},    128'(rk_idx),    128'h0);
        check({tag, " rnd_last"},  128'(rnd_last),  128'h0);
        check({tag, " rnd_en_de"}, 128'(rnd_en_de), 128'h0);
        check({tag, " rnd_block"}, rnd_block, 128'h0);
    endtask

    initial begin
        logic [127:0] key, blk, exp;
        logic         enc;
        int           hold;

        reset = 1'b1; in_valid = 1'b0; in_en_de = 1'b0; in_block = '0;
        flush = 1'b0; out_ready = 1'b0;
`ifdef AES_ROUND_SEQ_SINGLE_EN
        in_single = 1'b0; in_last = 1'b0;
`endif
        build_sbox();
        expand_key(C1_KEY);
        repeat (2) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // FIPS-197 C.1 encrypt and decrypt.
        start(1'b1, C1_PT, 1'b0);
        follow(1'b1, C1_CT, "c1_enc");
        drain();
        start(1'b0, C1_CT, 1'b0);
        follow(1'b0, C1_PT, "c1_dec");

        // Backpressure, then same-cycle accept on release.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp out_valid", 128'(out_valid), 128'(1'b1));
            check("bp out_block", out_block, C1_PT);
            check("bp in_ready", 128'(in_ready), 128'(1'b0));
        end
        out_ready = 1'b1;
        start(1'b1, C1_PT, 1'b0);
        follow(1'b1, C1_CT, "b2b");
        drain();

        // Flush in the 4th ROUND cycle.
        start(1'b1, C1_PT, 1'b0);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush in_ready", 128'(in_ready), 128'(1'b1));
        check("flush rk_idx", 128'(rk_idx), 128'h0);
        for (int i = 0; i < 12; i++) begin
            check("flush no out_valid", 128'(out_valid), 128'(1'b0));
            tick();
        end
        start(1'b1, C1_PT, 1'b0);
        follow(1'b1, C1_CT, "post_flush");
        drain();

        // Flush in DONE beats out_ready and blocks the pending accept.
        start(1'b0, C1_CT, 1'b0);
        follow(1'b0, C1_PT, "dec2");
        out_ready = 1'b1; in_valid = 1'b1; in_en_de = 1'b0; flush = 1'b1;
        #1 check("done flush in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1;
        check("done flush out_valid", 128'(out_valid), 128'(1'b0));
        check("done flush rk_idx", 128'(rk_idx), 128'h0);
        check("done flush in_ready idle", 128'(in_ready), 128'(1'b1));

        // Reset in the middle of an encrypt.
        start(1'b1, C1_PT, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("mid reset");
        reset = 1'b0;
        tick();

        // Flush together with in_valid in IDLE: request wins.
        start(1'b1, C1_PT, 1'b1);
        follow(1'b1, C1_CT, "idle_flush");
        drain();

        // Random keys, blocks, directions and result hold times.
        for (int n = 0; n < 24; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            blk = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom_range(0, 1));
            expand_key(key);
            exp = aes_ref(blk, enc);
            start(enc, blk, 1'b0);
            follow(enc, exp, "rand");
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("rand hold out_block", out_block, exp);
            end
            drain();
        end

`ifdef AES_ROUND_SEQ_SINGLE_EN
        expand_key(C1_KEY);
        in_single = 1'b1; in_last = 1'b1;
        start(1'b1, C1_PT, 1'b0);
        in_single = 1'b0; in_last = 1'b0;
        check("single rk_idx", 128'(rk_idx), 128'h0);
        check("single rnd_last", 128'(rnd_last), 128'(1'b1));
        tick();
        check("single out_valid", 128'(out_valid), 128'(1'b1));
        check("single out_block", out_block, dp_round(C1_PT, rk_file[0], 1'b1, 1'b1));
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
